// File: rtl/demosaic_pkg.sv
// rtl/demosaic_pkg.sv - shared pixel width, controller state type and frame-size helper
package demosaic_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    FILL,
    FLUSH,
    DRAIN,
    DONE
  } ctrl_state_t;

  // Number of pixels streamed into the demosaic per frame (FILL length).
  function automatic logic [31:0] frame_cycles(input int unsigned width, input int unsigned height);
    return 32'(width * height);
  endfunction

endpackage

// File: rtl/demosaic_frame_ctrl_if.sv
// rtl/demosaic_frame_ctrl_if.sv - upstream pixel handshake and demosaic-side signals
interface demosaic_frame_ctrl_if;
  import demosaic_pkg::*;

  logic [PIX_W-1:0] src_data;
  logic             src_valid;
  logic             src_ready;
  logic             dm_reset;
  logic [PIX_W-1:0] dm_data;
  logic             dm_valid;
  logic             dm_ovalid;
  logic             dm_done;

  // master: the frame controller; slave: source plus demosaic instance
  modport master (
    input  src_data, src_valid, dm_ovalid, dm_done,
    output src_ready, dm_reset, dm_data, dm_valid
  );

  modport slave (
    output src_data, src_valid, dm_ovalid, dm_done,
    input  src_ready, dm_reset, dm_data, dm_valid
  );

endinterface

// File: rtl/demosaic_ctrl_watchdog.sv
// rtl/demosaic_ctrl_watchdog.sv - DRAIN-state cycle counter that flags when the limit is reached
module demosaic_ctrl_watchdog (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [31:0] limit,
  output logic        expired
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 32'd1;
    end
  end

  // Fires on the limit-th enabled cycle so the FSM leaves exactly limit cycles after entry.
  assign expired = enable && (count == limit - 32'd1);

endmodule

// File: rtl/demosaic_frame_ctrl.sv
// rtl/demosaic_frame_ctrl.sv - frame sequencer for the demosaic; optional watchdog via DEMOSAIC_CTRL_TIMEOUT_EN
module demosaic_frame_ctrl
  import demosaic_pkg::*;
#(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240
`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  demosaic_frame_ctrl_if.master bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun,
  output logic [31:0]           out_pix_cnt
`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);

  localparam logic [31:0] FILL_LAST  = frame_cycles(WIDTH, HEIGHT) - 32'd1;
  localparam logic [31:0] FLUSH_LAST = 32'(2 * WIDTH) - 32'd1;

  ctrl_state_t      state;
  ctrl_state_t      state_next;
  logic [31:0]      pix_cnt;
  logic [31:0]      pix_cnt_next;
  logic             dm_valid_q;
  logic [PIX_W-1:0] dm_data_q;
  logic             counting;
  logic             drain_active;
  logic             wd_expired;

  assign drain_active = (state == DRAIN);
  assign counting     = (state == FILL) || (state == FLUSH) || (state == DRAIN);

`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
  demosaic_ctrl_watchdog u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .enable  (drain_active),
    .clear   (!drain_active),
    .limit   (32'(TIMEOUT_CYCLES)),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset || state == RST) begin
      timeout <= 1'b0;
    end else if (drain_active && !bus.dm_done && wd_expired) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    pix_cnt_next = '0;
    case (state)
      IDLE: begin
        if (start) state_next = RST;
      end
      RST: begin
        state_next = FILL;
      end
      FILL: begin
        if (pix_cnt == FILL_LAST) begin
          state_next = FLUSH;
        end else begin
          pix_cnt_next = pix_cnt + 32'd1;
        end
      end
      FLUSH: begin
        if (pix_cnt == FLUSH_LAST) begin
          state_next = DRAIN;
        end else begin
          pix_cnt_next = pix_cnt + 32'd1;
        end
      end
      DRAIN: begin
        if (bus.dm_done || wd_expired) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      dm_valid_q  <= 1'b0;
      dm_data_q   <= '0;
      underrun    <= 1'b0;
      out_pix_cnt <= '0;
    end else begin
      state   <= state_next;
      pix_cnt <= pix_cnt_next;

      // The demosaic cannot stall, so a missing source pixel becomes a zero slot.
      case (state)
        FILL: begin
          dm_valid_q <= 1'b1;
          dm_data_q  <= bus.src_valid ? bus.src_data : '0;
        end
        FLUSH: begin
          dm_valid_q <= 1'b1;
          dm_data_q  <= '0;
        end
        default: begin
          dm_valid_q <= 1'b0;
          dm_data_q  <= '0;
        end
      endcase

      if (state == RST) begin
        underrun    <= 1'b0;
        out_pix_cnt <= '0;
      end else begin
        if (state == FILL && !bus.src_valid) underrun <= 1'b1;
        if (counting && bus.dm_ovalid) out_pix_cnt <= out_pix_cnt + 32'd1;
      end
    end
  end

  assign bus.src_ready = !reset && (state == FILL);
  assign bus.dm_reset  = reset || (state == RST);
  assign bus.dm_valid  = dm_valid_q;
  assign bus.dm_data   = dm_data_q;
  assign busy          = !reset && (state != IDLE);
  assign frame_done    = !reset && (state == DONE);

endmodule

// File: tb/tb_demosaic_frame_ctrl.sv
// tb/tb_demosaic_frame_ctrl.sv - scoreboard bench for demosaic_frame_ctrl at WIDTH=4, HEIGHT=2
module tb_demosaic_frame_ctrl;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int NPIX  = W * H;
  localparam int NBEAT = NPIX + 2 * W;
`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic        underrun;
  logic [31:0] out_pix_cnt;
`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
  logic        timeout;
`endif

  demosaic_frame_ctrl_if bus ();

  demosaic_frame_ctrl #(
    .WIDTH  (W),
    .HEIGHT (H)
`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun),
    .out_pix_cnt (out_pix_cnt)
`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
    ,
    .timeout     (timeout)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [7:0] sb[$];
  int         cyc = 0;
  int         t0 = 0;
  bit         t0_valid = 0;
  int         pix_idx, drop_idx, done_delay, ov_n, beats, dmrst_cnt, fdone_cnt, exp_gap;
  logic [7:0] seed;
  bit         exp_underrun;

  task automatic begin_frame(input logic [7:0] s, input int drop, input int dd, input int nov);
    seed         = s;
    drop_idx     = drop;
    done_delay   = dd;
    ov_n         = nov;
    pix_idx      = 0;
    beats        = 0;
    dmrst_cnt    = 0;
    fdone_cnt    = 0;
    t0_valid     = 0;
    exp_underrun = (drop > 0);
    exp_gap      = (dd < 0) ? (2 + NBEAT - 1 + TO) : (2 + NBEAT + dd);
    sb.delete();
  endtask

  // One negedge: observe DUT outputs, then drive the source and demosaic models.
  task automatic tick();
    logic [7:0] exp_d;
    @(negedge clk);
    cyc++;
    if (busy && bus.dm_reset) begin
      dmrst_cnt++;
      t0       = cyc;
      t0_valid = 1;
    end
    if (bus.dm_valid) begin
      if (sb.size() == 0) begin
        check("dm_extra_beat", 1, 0);
      end else begin
        exp_d = sb.pop_front();
        check("dm_data", bus.dm_data, exp_d);
        if (t0_valid) check("beat_time", 32'(cyc - t0), 32'(beats + 2));
      end
      beats++;
    end
    if (frame_done) begin
      fdone_cnt++;
      check("sb_empty", sb.size(), 0);
      check("underrun_done", underrun, exp_underrun);
      check("pix_cnt_done", out_pix_cnt, ov_n);
      check("frame_latency", 32'(cyc - t0), exp_gap);
`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
      check("timeout_done", timeout, done_delay < 0);
`endif
      t0_valid = 0;
    end

    if (bus.dm_reset) bus.dm_done = 1'b0;
    else if (t0_valid && done_delay >= 0 && cyc == t0 + 1 + NBEAT + done_delay) bus.dm_done = 1'b1;
    bus.dm_ovalid = t0_valid && (cyc >= t0 + 10) && (cyc < t0 + 10 + ov_n);

    if (bus.src_ready) begin
      pix_idx++;
      if (pix_idx == drop_idx) begin
        bus.src_valid = 1'b0;
        bus.src_data  = 8'hAA;
        sb.push_back(8'h00);
      end else begin
        bus.src_valid = 1'b1;
        bus.src_data  = 8'(seed + pix_idx);
        sb.push_back(8'(seed + pix_idx));
      end
      if (pix_idx == NPIX) begin
        for (int i = 0; i < 2 * W; i++) sb.push_back(8'h00);
      end
    end else begin
      bus.src_valid = 1'b0;
      bus.src_data  = 8'h00;
    end
  endtask

  task automatic run_frame(input logic [7:0] s, input int drop, input int dd, input int nov, input bit extra);
    begin_frame(s, drop, dd, nov);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (extra) begin
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100 && beats < NBEAT; i++) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < 300 && fdone_cnt == 0; i++) tick();
    check("frame_done_seen", fdone_cnt, 1);
    repeat (4) tick();
    check("frame_done_count", fdone_cnt, 1);
    check("dm_reset_count", dmrst_cnt, 1);
    check("beat_count", beats, NBEAT);
    check("idle_busy", busy, 0);
    check("pix_cnt_hold", out_pix_cnt, nov);
    check("underrun_hold", underrun, exp_underrun);
  endtask

  initial begin
    bus.src_data  = 8'h00;
    bus.src_valid = 1'b0;
    bus.dm_ovalid = 1'b0;
    bus.dm_done   = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    begin_frame(8'h00, 0, 0, 0);
    repeat (3) tick();
    check("rst_src_ready", bus.src_ready, 0);
    check("rst_dm_valid", bus.dm_valid, 0);
    check("rst_dm_data", bus.dm_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_pix_cnt", out_pix_cnt, 0);
    check("rst_dm_reset", bus.dm_reset, 1);
`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
    check("rst_timeout", timeout, 0);
`endif
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("start_in_reset_ignored", busy, 0);

    run_frame(8'h00, 0, 2, 7, 1'b0);
    run_frame(8'h40, 3, 0, 3, 1'b0);
    run_frame(8'h80, 0, 4, 0, 1'b1);

    begin_frame(8'h10, 0, 1, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && pix_idx < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_dm_valid", bus.dm_valid, 0);
    check("abort_src_ready", bus.src_ready, 0);
    sb.delete();
    t0_valid = 0;
    repeat (4) tick();
    check("abort_no_frame_done", fdone_cnt, 0);
    check("abort_idle", busy, 0);

    run_frame(8'hC0, 0, 1, 5, 1'b0);
`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
    run_frame(8'h20, 0, -1, 2, 1'b0);
    check("timeout_sticky", timeout, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
